// File: rtl/mem_responder_rv.sv
// Memory/MMIO responder for the multi-cycle RISC-V core: word RAM, console TX FIFO and cycle counter.
// Optional 64-bit cycle counter is enabled by defining MEM_RESP_CYCLE_COUNTER_EN.
module mem_responder_rv #(
  parameter int    RAM_ADDR_WIDTH  = 12,
  parameter int    FIFO_DEPTH_LOG2 = 2,
  parameter string INIT_FILE       = ""
) (
  input  logic        iwClk,
  input  logic        iwnRst,
  input  logic [31:0] iwReadAddr,
  input  logic [31:0] iwWriteAddr,
  input  logic [31:0] iwWriteData,
  input  logic [3:0]  iwWstrb,
  output logic [31:0] owReadData,
  output logic [7:0]  owTxData,
  output logic        owTxValid,
  input  logic        iwTxReady
);

  localparam int RAM_WORDS = 1 << RAM_ADDR_WIDTH;
  localparam int DEPTH     = 1 << FIFO_DEPTH_LOG2;
  localparam int PW        = (FIFO_DEPTH_LOG2 > 0) ? FIFO_DEPTH_LOG2 : 1;
  localparam int CW        = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [27:0]   MMIO_PAGE = 28'h1000000;

  logic [31:0] ram_q [RAM_WORDS];
  logic [7:0]  fifo_q [DEPTH];

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;

  logic [3:0]  eff_strb_s;
  logic [31:0] eff_data_s;
  logic        wr_ram_s;
  logic        wr_mmio_s;
  logic [RAM_ADDR_WIDTH-1:0] wr_word_s;
  logic        push_req_s;
  logic        push_acc_s;
  logic        push_drop_s;
  logic        ovf_clr_s;
  logic        pop_s;
  logic        full_s;
  logic [31:0] status_s;
  logic [63:0] cycle_s;
  logic        unused_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? PW'(0) : p + PW'(1);
  endfunction

  assign unused_s = ^iwReadAddr[1:0];

  // Write lane alignment and address decode
  always_comb begin
    eff_strb_s = iwWstrb << iwWriteAddr[1:0];
    eff_data_s = iwWriteData << {iwWriteAddr[1:0], 3'b000};
    wr_ram_s   = (iwWriteAddr[31:RAM_ADDR_WIDTH+2] == '0);
    wr_mmio_s  = (iwWriteAddr[31:4] == MMIO_PAGE);
    wr_word_s  = iwWriteAddr[RAM_ADDR_WIDTH+1:2];
  end

  // RAM byte-lane writes; contents survive reset
  always_ff @(posedge iwClk) begin
    if (wr_ram_s) begin
      if (eff_strb_s[0]) ram_q[wr_word_s][7:0]   <= eff_data_s[7:0];
      if (eff_strb_s[1]) ram_q[wr_word_s][15:8]  <= eff_data_s[15:8];
      if (eff_strb_s[2]) ram_q[wr_word_s][23:16] <= eff_data_s[23:16];
      if (eff_strb_s[3]) ram_q[wr_word_s][31:24] <= eff_data_s[31:24];
    end
  end

  // TX FIFO next-state: push/pop arbitration, overflow and registered head
  always_comb begin
    pop_s       = tx_valid_q && iwTxReady;
    full_s      = (count_q == DEPTH_C);
    push_req_s  = wr_mmio_s && (iwWriteAddr[3:2] == 2'd0) && eff_strb_s[0];
    ovf_clr_s   = wr_mmio_s && (iwWriteAddr[3:2] == 2'd1) && eff_strb_s[0] && iwWriteData[2];
    push_acc_s  = push_req_s && (!full_s || pop_s);
    push_drop_s = push_req_s && !push_acc_s;

    rd_ptr_d = pop_s      ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_acc_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;

    case ({push_acc_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (push_drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_s) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    // The slot being written is the new head only when it lands at the next read pointer
    if (count_d == '0) begin
      tx_data_d = 8'd0;
    end else if (push_acc_s && (wr_ptr_q == rd_ptr_d)) begin
      tx_data_d = iwWriteData[7:0];
    end else begin
      tx_data_d = fifo_q[rd_ptr_d];
    end
    tx_valid_d = (count_d != '0);
  end

  // FIFO storage, no reset needed since pointers gate visibility
  always_ff @(posedge iwClk) begin
    if (push_acc_s) fifo_q[wr_ptr_q] <= iwWriteData[7:0];
  end

  // FIFO control registers and registered TX outputs
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      tx_data_q  <= 8'd0;
      tx_valid_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign owTxData  = tx_data_q;
  assign owTxValid = tx_valid_q;

`ifdef MEM_RESP_CYCLE_COUNTER_EN
  logic [63:0] cycle_q;

  // Free-running cycle counter
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      cycle_q <= 64'd0;
    end else begin
      cycle_q <= cycle_q + 64'd1;
    end
  end

  assign cycle_s = cycle_q;
`else
  assign cycle_s = 64'd0;
`endif

  assign status_s = {16'd0, 8'(count_q), 5'd0, ovf_q, (count_q == '0), full_s};

  // Combinational read-first path; the core samples it on the falling edge
  always_comb begin
    owReadData = 32'd0;
    if (iwReadAddr[31:RAM_ADDR_WIDTH+2] == '0) begin
      owReadData = ram_q[iwReadAddr[RAM_ADDR_WIDTH+1:2]];
    end else if (iwReadAddr[31:4] == MMIO_PAGE) begin
      case (iwReadAddr[3:2])
        2'd0:    owReadData = 32'd0;
        2'd1:    owReadData = status_s;
        2'd2:    owReadData = cycle_s[31:0];
        2'd3:    owReadData = cycle_s[63:32];
        default: owReadData = 32'd0;
      endcase
    end else begin
      owReadData = 32'd0;
    end
  end

endmodule
